// File: rtl/window_motion_ctrl_pkg.sv
// ============================================================================
// Module      : window_motion_ctrl_pkg
// Description : Shared types and helpers for the window-lift motion
//               controller: state encoding, default duty resolution and
//               width helpers for the duty and timer datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package window_motion_ctrl_pkg;

  // Default number of duty steps (20 steps of 5 %).
  localparam int T_DIV_DEF = 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEAD  = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_BRAKE = 3'd4,
    S_PDEAD = 3'd5,
    S_REV   = 3'd6
  } state_t;

  // Bits needed to hold a duty value in 0..t_div.
  function automatic int duty_width(input int t_div);
    return (t_div < 1) ? 1 : $clog2(t_div + 1);
  endfunction

  // Bits needed for a cycle counter that counts 0..max_cyc-1.
  function automatic int cyc_width(input int max_cyc);
    return (max_cyc < 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_motion_ctrl_timer.sv
// ============================================================================
// Module      : motion_timer
// Description : Shared cycle timer. Counts up from zero every cycle; load
//               clears it. done is high while the count equals the terminal
//               count, so a terminal count of N-1 marks the last cycle of an
//               N-cycle interval that started with a load.
// Ports       : sysclk - clock
//               rst_n  - asynchronous active-low reset
//               load   - synchronous clear of the count
//               tc     - terminal count (interval length minus one)
//               done   - terminal count reached (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motion_timer #(
  parameter int WIDTH = 4
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] tc,
  output logic             done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign done = (r_cnt == tc);

endmodule

`default_nettype wire

// File: rtl/window_motion_ctrl.sv
// ============================================================================
// Module      : window_motion_ctrl
// Description : Window-lift motor sequencing controller. Converts debounced
//               up/down commands, end-stop limits and the pinch flag into a
//               duty step and direction for the PWM stage, with dead time,
//               soft start/stop ramps and automatic pinch reversal.
// Ports       : sysclk    - system clock
//               rst_n     - asynchronous active-low reset
//               cmd_up    - close request (level)
//               cmd_down  - open request (level)
//               top_limit - fully-closed end stop
//               bot_limit - fully-open end stop
//               pinch     - obstruction detected
//               duty      - duty step 0..T_DIV (registered)
//               dir       - 1 = close, 0 = open (registered)
//               busy      - not idle (registered)
//               fault     - one-cycle pulse on pinch detection (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_motion_ctrl
  import window_motion_ctrl_pkg::*;
#(
  parameter int T_DIV    = T_DIV_DEF,
  parameter int DUTY_MAX = 20,
  parameter int DUTY_REV = 10,
  parameter int STEP_CYC = 5_000_000,
  parameter int DEAD_CYC = 1_000_000,
  parameter int REV_CYC  = 50_000_000
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic                        cmd_up,
  input  logic                        cmd_down,
  input  logic                        top_limit,
  input  logic                        bot_limit,
  input  logic                        pinch,
  output logic [duty_width(T_DIV)-1:0] duty,
  output logic                        dir,
  output logic                        busy,
  output logic                        fault
);

  localparam int DW      = duty_width(T_DIV);
  localparam int MAX_A   = (STEP_CYC > DEAD_CYC) ? STEP_CYC : DEAD_CYC;
  localparam int MAX_CYC = (MAX_A > REV_CYC) ? MAX_A : REV_CYC;
  localparam int TW      = cyc_width(MAX_CYC);

  localparam logic [DW-1:0] C_ONE  = DW'(1);
  localparam logic [DW-1:0] C_DMAX = DW'(DUTY_MAX);
  localparam logic [DW-1:0] C_DREV = DW'(DUTY_REV);

  // Terminal counts are interval length minus one (see motion_timer).
  localparam logic [TW-1:0] C_STEP_TC = TW'(STEP_CYC - 1);
  localparam logic [TW-1:0] C_DEAD_TC = TW'(DEAD_CYC - 1);
  localparam logic [TW-1:0] C_REV_TC  = TW'(REV_CYC - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [DW-1:0]   w_next_duty;
  logic            w_next_dir;
  logic            w_next_fault;
  logic            w_step;
  logic            w_tmr_load;
  logic [TW-1:0]   w_tmr_tc;
  logic            w_tmr_done;
  logic            w_lim_hit;
  logic            w_cmd_act;
  logic            w_pinch_hit;

  motion_timer #(
    .WIDTH (TW)
  ) u_timer (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .load   (w_tmr_load),
    .tc     (w_tmr_tc),
    .done   (w_tmr_done)
  );

  // State and output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      duty    <= '0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      duty    <= w_next_duty;
      dir     <= w_next_dir;
      busy    <= (w_next_state != S_IDLE);
      fault   <= w_next_fault;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_next_state = r_state;
    w_next_duty  = duty;
    w_next_dir   = dir;
    w_next_fault = 1'b0;
    w_step       = 1'b0;
    w_tmr_tc     = '0;

    // Direction-relative views of the inputs.
    w_lim_hit   = dir ? top_limit : bot_limit;
    w_cmd_act   = dir ? cmd_up : cmd_down;
    w_pinch_hit = dir & pinch;

    case (r_state)
      S_IDLE: begin
        w_next_duty = '0;
        if (cmd_up && !cmd_down && !top_limit) begin
          w_next_dir   = 1'b1;
          w_next_state = S_DEAD;
        end else if (cmd_down && !cmd_up && !bot_limit) begin
          w_next_dir   = 1'b0;
          w_next_state = S_DEAD;
        end
      end

      S_DEAD, S_RAMP, S_RUN, S_BRAKE: begin
        w_tmr_tc = (r_state == S_DEAD) ? C_DEAD_TC : C_STEP_TC;
        if (w_lim_hit) begin
          w_next_duty  = '0;
          w_next_state = S_IDLE;
        end else if (w_pinch_hit) begin
          w_next_duty  = '0;
          w_next_fault = 1'b1;
          w_next_dir   = 1'b0;
          w_next_state = S_PDEAD;
        end else if (!w_cmd_act && (r_state != S_BRAKE)) begin
          // Duty is still zero in DEAD, so nothing to ramp down.
          w_next_state = (r_state == S_DEAD) ? S_IDLE : S_BRAKE;
        end else if (w_tmr_done) begin
          case (r_state)
            S_DEAD: begin
              w_next_duty  = C_ONE;
              w_next_state = (DUTY_MAX == 1) ? S_RUN : S_RAMP;
            end
            S_RAMP: begin
              w_step      = 1'b1;
              w_next_duty = duty + C_ONE;
              if ((duty + C_ONE) == C_DMAX) begin
                w_next_state = S_RUN;
              end
            end
            S_BRAKE: begin
              w_step = 1'b1;
              if (duty <= C_ONE) begin
                w_next_duty  = '0;
                w_next_state = S_IDLE;
              end else begin
                w_next_duty = duty - C_ONE;
              end
            end
            default: begin
              w_next_duty = C_DMAX;
            end
          endcase
        end
      end

      S_PDEAD: begin
        w_tmr_tc    = C_DEAD_TC;
        w_next_duty = '0;
        w_next_dir  = 1'b0;
        if (w_tmr_done) begin
          w_next_duty  = C_DREV;
          w_next_state = S_REV;
        end
      end

      S_REV: begin
        w_tmr_tc = C_REV_TC;
        if (bot_limit || w_tmr_done) begin
          w_next_duty  = '0;
          w_next_state = S_IDLE;
        end
      end

      default: begin
        w_next_duty  = '0;
        w_next_state = S_IDLE;
      end
    endcase

    // Timer restarts on every state entry and every ramp step; it is held
    // clear in states that do not time anything.
    w_tmr_load = (w_next_state != r_state) || w_step ||
                 (r_state == S_IDLE) || (r_state == S_RUN);
  end

endmodule

`default_nettype wire

// File: tb/tb_window_motion_ctrl.sv
`default_nettype none

module tb_window_motion_ctrl;

  logic       sysclk;
  logic       rst_n;
  logic       cmd_up;
  logic       cmd_down;
  logic       top_limit;
  logic       bot_limit;
  logic       pinch;
  logic [4:0] duty;
  logic       dir;
  logic       busy;
  logic       fault;

  int checks;
  int errors;

  window_motion_ctrl #(
    .T_DIV    (20),
    .DUTY_MAX (20),
    .DUTY_REV (10),
    .STEP_CYC (4),
    .DEAD_CYC (3),
    .REV_CYC  (10)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .cmd_up    (cmd_up),
    .cmd_down  (cmd_down),
    .top_limit (top_limit),
    .bot_limit (bot_limit),
    .pinch     (pinch),
    .duty      (duty),
    .dir       (dir),
    .busy      (busy),
    .fault     (fault)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Advance n active edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_up = 1'b0; cmd_down = 1'b0;
    top_limit = 1'b0; bot_limit = 1'b0; pinch = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    checks++; if (duty !== 5'd0) begin errors++; $display("FAIL reset_duty got=%0d exp=0", duty); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
  endtask

  // Close ramp from edge 0, then release in RUN.
  task automatic test_close_ramp_release();
    cmd_up = 1'b1;
    step(1);   // edge 1
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL ramp_dir got=%b exp=1", dir); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy got=%b exp=1", busy); end
    checks++; if (duty !== 5'd0) begin errors++; $display("FAIL ramp_dead_duty got=%0d exp=0", duty); end
    step(2);   // edge 3
    checks++; if (duty !== 5'd0) begin errors++; $display("FAIL ramp_dead_end got=%0d exp=0", duty); end
    step(1);   // edge 4
    checks++; if (duty !== 5'd1) begin errors++; $display("FAIL ramp_first got=%0d exp=1", duty); end
    step(4);   // edge 8
    checks++; if (duty !== 5'd2) begin errors++; $display("FAIL ramp_second got=%0d exp=2", duty); end
    step(71);  // edge 79
    checks++; if (duty !== 5'd19) begin errors++; $display("FAIL ramp_e79 got=%0d exp=19", duty); end
    step(1);   // edge 80
    checks++; if (duty !== 5'd20) begin errors++; $display("FAIL ramp_e80 got=%0d exp=20", duty); end
    step(10);  // edge 90
    checks++; if (duty !== 5'd20) begin errors++; $display("FAIL run_hold got=%0d exp=20", duty); end
    cmd_up = 1'b0;
    step(1);   // release sampled: s
    checks++; if (duty !== 5'd20 || busy !== 1'b1) begin errors++; $display("FAIL brake_entry duty=%0d busy=%b exp=20/1", duty, busy); end
    step(4);   // s+4
    checks++; if (duty !== 5'd19) begin errors++; $display("FAIL brake_first got=%0d exp=19", duty); end
    step(75);  // s+79
    checks++; if (duty !== 5'd1 || busy !== 1'b1) begin errors++; $display("FAIL brake_s79 duty=%0d busy=%b exp=1/1", duty, busy); end
    step(1);   // s+80
    checks++; if (duty !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL brake_done duty=%0d busy=%b exp=0/0", duty, busy); end
  endtask

  task automatic test_pinch();
    cmd_up = 1'b1;
    step(48);  // edge 48
    checks++; if (duty !== 5'd12) begin errors++; $display("FAIL pinch_pre got=%0d exp=12", duty); end
    pinch = 1'b1;
    step(1);   // edge 49
    checks++; if (duty !== 5'd0) begin errors++; $display("FAIL pinch_duty got=%0d exp=0", duty); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL pinch_fault got=%b exp=1", fault); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL pinch_dir got=%b exp=0", dir); end
    pinch = 1'b0; cmd_up = 1'b0;
    step(1);   // edge 50
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL pinch_single got=%b exp=0", fault); end
    step(1);   // edge 51
    checks++; if (duty !== 5'd0 || busy !== 1'b1) begin errors++; $display("FAIL pdead duty=%0d busy=%b exp=0/1", duty, busy); end
    step(1);   // edge 52
    checks++; if (duty !== 5'd10) begin errors++; $display("FAIL rev_start got=%0d exp=10", duty); end
    step(9);   // edge 61
    checks++; if (duty !== 5'd10 || busy !== 1'b1) begin errors++; $display("FAIL rev_hold duty=%0d busy=%b exp=10/1", duty, busy); end
    step(1);   // edge 62
    checks++; if (duty !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL rev_end duty=%0d busy=%b exp=0/0", duty, busy); end
  endtask

  task automatic test_top_limit();
    cmd_up = 1'b1;
    step(81);
    checks++; if (duty !== 5'd20) begin errors++; $display("FAIL lim_pre got=%0d exp=20", duty); end
    top_limit = 1'b1;
    step(1);
    checks++; if (duty !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL top_limit duty=%0d busy=%b exp=0/0", duty, busy); end
    step(3);   // command still high against the limit
    checks++; if (busy !== 1'b0 || duty !== 5'd0) begin errors++; $display("FAIL top_blocked busy=%b duty=%0d exp=0/0", busy, duty); end
    cmd_up = 1'b0; top_limit = 1'b0;
    step(1);
  endtask

  task automatic test_pinch_opening();
    cmd_down = 1'b1;
    step(1);   // edge 1
    checks++; if (dir !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL open_start dir=%b busy=%b exp=0/1", dir, busy); end
    step(4);   // edge 5
    pinch = 1'b1;
    step(1);   // edge 6
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL open_pinch_fault got=%b exp=0", fault); end
    step(2);   // edge 8
    checks++; if (duty !== 5'd2) begin errors++; $display("FAIL open_pinch_ramp got=%0d exp=2", duty); end
    pinch = 1'b0; cmd_down = 1'b0;
    step(9);   // edge 17: release sampled at 9, zero after 8 more
    checks++; if (duty !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL open_brake duty=%0d busy=%b exp=0/0", duty, busy); end
  endtask

  task automatic test_bot_limit_rev();
    cmd_up = 1'b1;
    step(1);   // edge 1, DEAD closing
    pinch = 1'b1;
    step(1);   // edge 2, PDEAD
    checks++; if (fault !== 1'b1 || duty !== 5'd0) begin errors++; $display("FAIL dead_pinch fault=%b duty=%0d exp=1/0", fault, duty); end
    pinch = 1'b0; cmd_up = 1'b0;
    step(3);   // edge 5, REV
    checks++; if (duty !== 5'd10) begin errors++; $display("FAIL rev2_start got=%0d exp=10", duty); end
    step(2);
    bot_limit = 1'b1;
    step(1);
    checks++; if (duty !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL rev_bot_limit duty=%0d busy=%b exp=0/0", duty, busy); end
    bot_limit = 1'b0;
    step(1);
  endtask

  task automatic test_conflict();
    cmd_up = 1'b1; cmd_down = 1'b1;
    step(5);
    checks++; if (busy !== 1'b0 || duty !== 5'd0) begin errors++; $display("FAIL conflict busy=%b duty=%0d exp=0/0", busy, duty); end
    cmd_up = 1'b0; cmd_down = 1'b0;
    step(1);
  endtask

  task automatic test_reset_midramp();
    cmd_up = 1'b1;
    step(10);
    checks++; if (duty !== 5'd2) begin errors++; $display("FAIL rst_pre got=%0d exp=2", duty); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (duty !== 5'd0 || dir !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset duty=%0d dir=%b busy=%b exp=0/0/0", duty, dir, busy); end
    cmd_up = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(5);
    checks++; if (busy !== 1'b0 || duty !== 5'd0) begin errors++; $display("FAIL post_reset_idle busy=%b duty=%0d exp=0/0", busy, duty); end
    cmd_up = 1'b1;
    step(1);
    checks++; if (busy !== 1'b1 || dir !== 1'b1) begin errors++; $display("FAIL restart busy=%b dir=%b exp=1/1", busy, dir); end
    cmd_up = 1'b0;
    step(1);   // release in DEAD returns straight to IDLE
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dead_release busy=%b exp=0", busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_close_ramp_release();
    test_pinch();
    test_top_limit();
    test_pinch_opening();
    test_bot_limit_rev();
    test_conflict();
    test_reset_midramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
